letc_core_rf: RTL and testbench
===============================

Name: letc_core_rf

Overview:
- Parametrised integer register file for the LETC core, the successor to the fixed 32 x 32-bit register index/word types in the shared core package.
- Generalised in data width, register count and read-port count.
- Storage is an unreset array, so the block runs a post-reset zero-initialisation sequence.
- Sits between decode (reads) and writeback (writes). Reads are synchronous, one-cycle latency.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, register count; power of two, >= 2; register 0 hardwired to zero.
- NUM_RD_PORTS, 2, number of independent read ports, >= 1.
- IDX_W (localparam), $clog2(NUM_REGS), index width; equals 5 at defaults, matching reg_index_t.

Ports:
- i_clk  in  1  core clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- o_init_done  out  1  high once zero-init is complete; writes and reads are serviced only when high
- i_rd_en  in  NUM_RD_PORTS  per-port read enable
- i_rd_idx  in  NUM_RD_PORTS*IDX_W  per-port read index; port p occupies bits [p*IDX_W +: IDX_W]
- o_rd_data  out  NUM_RD_PORTS*XLEN  per-port registered read data; same packing as i_rd_idx
- i_wr_en  in  1  write enable
- i_wr_idx  in  IDX_W  write index
- i_wr_data  in  XLEN  write data

Behaviour:
- Reset (async assert): state=INIT, init counter=1, o_init_done=0, all o_rd_data=0. Array contents are not reset.
- FSM states and transitions:
  - INIT: each rising edge writes 0 to array[counter], then counter increments. The edge that writes index NUM_REGS-1 moves the FSM to READY.
  - READY: terminal until the next reset.
- o_init_done is registered: 0 in INIT, 1 in READY. With defaults it rises after exactly 31 edges following reset deassertion.
- In INIT:
  - i_wr_en is ignored.
  - Every port with i_rd_en=1 loads 0 into o_rd_data.
  - Ports with i_rd_en=0 hold their value.
- Reset asserted mid-INIT or mid-READY returns immediately to INIT with counter=1, and initialisation restarts from scratch.
- Write (READY):
  - If i_wr_en=1 and i_wr_idx!=0, array[i_wr_idx] <= i_wr_data on the edge.
  - Writes to index 0 are discarded.
- Read (READY), per port p independently:
  - If i_rd_en[p]=1, o_rd_data[p] <= (idx==0) ? 0 : array[idx] at the edge, so data is visible one cycle after the request.
  - If i_rd_en[p]=0, o_rd_data[p] holds its previous value.
- Multiple ports may read the same index in the same cycle; all receive identical data.
- Same-cycle read and write of the same nonzero index: the read returns the OLD value (read-before-write), unless the optional feature below is enabled.
- There is a single write port, so write collisions cannot occur.
- No X may ever reach o_rd_data after reset, because every register is initialised before o_init_done rises.

Optional Feature:
- Macro: LETC_CORE_RF_WRITE_BYPASS_EN.
- Defined: a read on port p with i_rd_en[p]=1, in READY, with i_wr_en=1 and i_wr_idx==rd_idx!=0 returns i_wr_data (write-first forwarding). Index 0 still returns 0.
- Not defined: read-before-write as specified above, and no bypass mux is instantiated.

Test Plan:
- Reset then idle, defaults -> o_init_done=0 for the first 30 edges after deassertion, 1 after edge 31. Read of every index 1..31 afterwards returns 0x00000000.
- In READY: write idx 5 = 0xDEADBEEF; next cycle read port0 idx 5, port1 idx 5 -> both o_rd_data = 0xDEADBEEF one cycle later.
- Write idx 0 = 0xFFFFFFFF, then read idx 0 on all ports -> 0x00000000.
- Idx 7 holds 0x11111111; same cycle write idx 7 = 0x22222222 and read idx 7 -> 0x11111111 without the macro, 0x22222222 with LETC_CORE_RF_WRITE_BYPASS_EN. The following read returns 0x22222222 in both builds.
- Read port0 idx 3 (0xA5A5A5A5), then drop i_rd_en[0] for 4 cycles while writing idx 3 = 0x0 -> o_rd_data port0 stays 0xA5A5A5A5.
- Write idx 9 = 0x12345678, pulse i_rst for one cycle mid-run -> o_init_done=0 and o_rd_data=0 immediately (asynchronously). After 31 edges o_init_done=1 and a read of idx 9 returns 0x00000000. Also with NUM_REGS=16, NUM_RD_PORTS=3, XLEN=64 -> done after 15 edges.

Source files
------------

// File: rtl/letc_core_rf.sv
// LETC core integer register file: parametrised width/depth/read ports, synchronous reads,
// post-reset zero-init sequence. Optional write-first forwarding: LETC_CORE_RF_WRITE_BYPASS_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_INIT  | zeroing array[1..NUM_REGS-1], one entry per edge; no writes
// ST_READY | normal operation, terminal until the next reset
module letc_core_rf #(
    parameter  int XLEN         = 32,
    parameter  int NUM_REGS     = 32,
    parameter  int NUM_RD_PORTS = 2,
    localparam int IDX_W        = $clog2(NUM_REGS)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    output logic                           o_init_done,
    input  logic [NUM_RD_PORTS-1:0]        i_rd_en,
    input  logic [NUM_RD_PORTS*IDX_W-1:0]  i_rd_idx,
    output logic [NUM_RD_PORTS*XLEN-1:0]   o_rd_data,
    input  logic                           i_wr_en,
    input  logic [IDX_W-1:0]               i_wr_idx,
    input  logic [XLEN-1:0]                i_wr_data
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t            state;
    logic [IDX_W-1:0]  init_cnt;

    logic [XLEN-1:0]   regs [NUM_REGS];
    logic              arr_we;
    logic [IDX_W-1:0]  arr_widx;
    logic [XLEN-1:0]   arr_wdata;

    logic [XLEN-1:0]   rd_word [NUM_RD_PORTS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_INIT;
            init_cnt    <= IDX_W'(1);
            o_init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + IDX_W'(1);
                    if (init_cnt == LAST_IDX) begin
                        state       <= ST_READY;
                        o_init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                    o_init_done <= 1'b1;
                end
                default: begin
                    state       <= ST_INIT;
                    o_init_done <= 1'b0;
                end
            endcase
        end
    end

    // Entry 0 is never written; reads of index 0 are forced to zero instead.
    always_comb begin
        arr_we    = 1'b0;
        arr_widx  = init_cnt;
        arr_wdata = '0;
        if (state == ST_INIT) begin
            arr_we = 1'b1;
        end else if (i_wr_en && (i_wr_idx != '0)) begin
            arr_we    = 1'b1;
            arr_widx  = i_wr_idx;
            arr_wdata = i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (arr_we) begin
            regs[arr_widx] <= arr_wdata;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_word[p] = '0;
            if ((state == ST_READY) && (i_rd_idx[p*IDX_W +: IDX_W] != '0)) begin
                rd_word[p] = regs[i_rd_idx[p*IDX_W +: IDX_W]];
`ifdef LETC_CORE_RF_WRITE_BYPASS_EN
                if (i_wr_en && (i_wr_idx == i_rd_idx[p*IDX_W +: IDX_W])) begin
                    rd_word[p] = i_wr_data;
                end
`endif
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_data <= '0;
        end else begin
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                if (i_rd_en[p]) begin
                    o_rd_data[p*XLEN +: XLEN] <= rd_word[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_letc_core_rf.sv
// Self-checking bench for letc_core_rf: default instance with a read scoreboard plus a
// 16-entry / 3-port / 64-bit instance sharing clock and reset.
module tb_letc_core_rf;

    logic        clk;
    logic        rst;

    logic        a_done;
    logic [1:0]  a_rd_en;
    logic [9:0]  a_rd_idx;
    logic [63:0] a_rd_data;
    logic        a_wr_en;
    logic [4:0]  a_wr_idx;
    logic [31:0] a_wr_data;

    logic         b_done;
    logic [2:0]   b_rd_en;
    logic [11:0]  b_rd_idx;
    logic [191:0] b_rd_data;
    logic         b_wr_en;
    logic [3:0]   b_wr_idx;
    logic [63:0]  b_wr_data;

    letc_core_rf dut_a (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_init_done (a_done),
        .i_rd_en     (a_rd_en),
        .i_rd_idx    (a_rd_idx),
        .o_rd_data   (a_rd_data),
        .i_wr_en     (a_wr_en),
        .i_wr_idx    (a_wr_idx),
        .i_wr_data   (a_wr_data)
    );

    letc_core_rf #(.XLEN(64), .NUM_REGS(16), .NUM_RD_PORTS(3)) dut_b (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_init_done (b_done),
        .i_rd_en     (b_rd_en),
        .i_rd_idx    (b_rd_idx),
        .o_rd_data   (b_rd_data),
        .i_wr_en     (b_wr_en),
        .i_wr_idx    (b_wr_idx),
        .i_wr_data   (b_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [32];
    logic [31:0] model_out [2];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem[i] = '0;
        model_out[0] = '0;
        model_out[1] = '0;
    endtask

    // One READY cycle on dut_a; every port's expected output is queued, then checked after the edge.
    task automatic cyc(input logic [1:0] ren, input logic [4:0] i0, input logic [4:0] i1,
                       input logic wen, input logic [4:0] widx, input logic [31:0] wd,
                       input string tag);
        logic [4:0]  ix [2];
        logic [31:0] e;
        exp_t        x;
        ix[0] = i0;
        ix[1] = i1;
        a_rd_en   = ren;
        a_rd_idx  = {i1, i0};
        a_wr_en   = wen;
        a_wr_idx  = widx;
        a_wr_data = wd;
        for (int p = 0; p < 2; p++) begin
            if (ren[p]) begin
                e = (ix[p] == 5'd0) ? 32'h0 : mem[ix[p]];
`ifdef LETC_CORE_RF_WRITE_BYPASS_EN
                if (wen && (widx == ix[p]) && (ix[p] != 5'd0)) e = wd;
`endif
                model_out[p] = e;
            end
            sb.push_back('{tag, p, model_out[p]});
        end
        if (wen && (widx != 5'd0)) mem[widx] = wd;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk($sformatf("%s_p%0d", x.tag, x.port), {32'h0, a_rd_data[x.port*32 +: 32]}, {32'h0, x.data});
        end
        a_rd_en = '0;
        a_wr_en = 1'b0;
    endtask

    // Reset has just been released (1 ns after an edge); count edges until both instances report done.
    task automatic init_wait(input string tag);
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_a_done_e%0d", tag, k), {63'h0, a_done}, {63'h0, (k >= 31)});
            if (k <= 16)
                chk($sformatf("%s_b_done_e%0d", tag, k), {63'h0, b_done}, {63'h0, (k >= 15)});
        end
    endtask

    initial begin
        rst = 1'b1;
        a_rd_en = '0; a_rd_idx = '0; a_wr_en = 1'b0; a_wr_idx = '0; a_wr_data = '0;
        b_rd_en = '0; b_rd_idx = '0; b_wr_en = 1'b0; b_wr_idx = '0; b_wr_data = '0;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_done", {63'h0, a_done}, 64'h0);
        chk("rst_a_data", a_rd_data, 64'h0);
        chk("rst_b_done", {63'h0, b_done}, 64'h0);
        chk("rst_b_data", b_rd_data[63:0], 64'h0);

        rst = 1'b0;
        init_wait("init1");

        for (int i = 1; i <= 31; i++)
            cyc(2'b11, 5'(i), 5'(32 - i), 1'b0, 5'd0, 32'h0, $sformatf("zero_%0d", i));

        cyc(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, "wr5");
        cyc(2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, "rd5");

        cyc(2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, "wr0");
        cyc(2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, "rd0");

        cyc(2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 32'h1111_1111, "wr7a");
        cyc(2'b11, 5'd7, 5'd7, 1'b1, 5'd7, 32'h2222_2222, "rw7");
        cyc(2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0, "rd7");

        cyc(2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 32'hA5A5_A5A5, "wr3");
        cyc(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, "rd3");
        cyc(2'b00, 5'd3, 5'd3, 1'b1, 5'd3, 32'h0, "hold3_0");
        for (int i = 1; i < 4; i++)
            cyc(2'b00, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0, $sformatf("hold3_%0d", i));
        cyc(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, "rd3_new");

        for (int i = 0; i < 40; i++)
            cyc(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom),
                $sformatf("rnd_%0d", i));

        b_wr_en = 1'b1; b_wr_idx = 4'd10; b_wr_data = 64'h0123_4567_89AB_CDEF;
        @(posedge clk);
        #1;
        b_wr_idx = 4'd0; b_wr_data = '1;
        @(posedge clk);
        #1;
        b_wr_en = 1'b0;
        b_rd_en = 3'b111; b_rd_idx = {4'd0, 4'd10, 4'd10};
        @(posedge clk);
        #1;
        b_rd_en = '0;
        chk("b_rd10_p0", b_rd_data[63:0],    64'h0123_4567_89AB_CDEF);
        chk("b_rd10_p1", b_rd_data[127:64],  64'h0123_4567_89AB_CDEF);
        chk("b_rd0_p2",  b_rd_data[191:128], 64'h0);

        cyc(2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 32'h1234_5678, "wr9");
        cyc(2'b11, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0, "rd9");
        #2;
        rst = 1'b1;
        #1;
        chk("arst_a_done", {63'h0, a_done}, 64'h0);
        chk("arst_a_data", a_rd_data, 64'h0);
        chk("arst_b_done", {63'h0, b_done}, 64'h0);
        chk("arst_b_data", b_rd_data, 192'h0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        init_wait("init2");
        cyc(2'b11, 5'd9, 5'd5, 1'b0, 5'd0, 32'h0, "rd9_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
